stall_logic: RTL and testbench
==============================

# stall_logic

Load-use hazard detector for the five-stage pipeline. It compares the instruction in D/X ("A", the producer) against the instruction in F/D ("B", the consumer). It raises `stallLW` when B needs a register that A's load has not yet produced, so F/D and PC hold and a bubble is injected into D/X. It also keeps a registered stall flag and a saturating stall counter for pipeline-control bookkeeping and debug.

## Interface
Parameters:
- `CNT_W`, 16: width of `stall_count`.

Ports (fixed order; clock and reset first, then the functional ports):
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `is_not_noop`  in  1  A is a valid, non-bubble instruction.
- `opcodeA`  in  5  opcode of A (D/X).
- `opcodeB`  in  5  opcode of B (F/D).
- `alu_opcodeA`  in  5  ALU op field of A (meaningful when `opcodeA`=00000).
- `alu_opcodeB`  in  5  ALU op field of B (meaningful when `opcodeB`=00000).
- `a_write`  in  5  destination register of A.
- `b_read2`  in  5  second decoded source register of B.
- `b_read1`  in  5  first decoded source register of B.
- `stallLW`  out  1  combinational stall request.
- `stall_q`  out  1  `stallLW` registered (previous cycle).
- `stall_count`  out  CNT_W  number of stall cycles since reset, saturating.

## Operation
- Opcodes:
  - R-type 00000; bne 00010; jr 00100; addi 00101; blt 00110; sw 00111; lw 01000; bex 10110.
  - ALU ops: sll 00100, sra 00101, mul 00110, div 00111.
- Producer hit `prodA` = `is_not_noop` & (`opcodeA`==01000) & (`a_write`!=0).
- Use of `b_read1`: `opcodeB` ∈ {00000, 00010, 00100, 00101, 00110, 00111, 01000}.
- Use of `b_read2`: `opcodeB` ∈ {00010, 00110, 10110}, or `opcodeB`==00000 with `alu_opcodeB` ∉ {00100, 00101}.
  - sw data (`b_read2` of sw) never stalls; it is covered by the W→M bypass.
- `stallLW` = !`reset` & `prodA` & ((use1 & `b_read1`==`a_write`) | (use2 & `b_read2`==`a_write`)).
- Register $0 never causes a stall.
- All opcodes not listed above: no use of either read port, so no stall.
- `stallLW` is purely combinational from the inputs. No state feeds it.
- `stall_q` ← `stallLW` each cycle.
- `stall_count` increments when `stallLW`=1 and holds at all-ones.
- `alu_opcodeA` is ignored unless the configuration macro below is defined.

## Timing
- `stallLW`: zero-cycle latency. It must settle within the same cycle the F/D and D/X registers update.
- `stall_q` and `stall_count`: update on the rising edge of `clock`; one-cycle latency relative to `stallLW`.
- Reset (synchronous, rising edge with `reset`=1):
  - `stall_q`=0, `stall_count`=0.
  - `stallLW` is forced to 0 combinationally while `reset`=1.
- Reset mid-stall: the counter clears on the next edge, and that cycle is not counted.
- Back-to-back stalls are legal; each cycle is counted. Normally the bubble turns A into a noop on the next cycle.
- Saturation: at 2^CNT_W−1, further stalls leave the value unchanged. There is no wrap.

## Configuration
- `STALL_LOGIC_MULDIV_EN`:
  - Defined: `prodA` also fires for `opcodeA`==00000 with `alu_opcodeA` ∈ {00110 mul, 00111 div}, same `is_not_noop` and `a_write`!=0 conditions. This covers multdiv results that are not bypassable from X.
  - Undefined: only lw produces stalls, and `alu_opcodeA` is unused.

## Test plan
- A=lw (`opcodeA`=01000), `a_write`=5, valid; B=add (00000/00000), `b_read1`=5 → `stallLW`=1; `stall_count` becomes 1 after the edge.
- Same A; B=sw (00111), `b_read2`=5, `b_read1`=7 → `stallLW`=0. Then `b_read1`=5 → `stallLW`=1.
- A=lw, `a_write`=0, `b_read1`=`b_read2`=0 → 0. A=lw, `is_not_noop`=0, matching reads → 0.
- B=sll (00000/00100), `b_read2`=`a_write`=9, `b_read1`=3 → 0. B=bne, `b_read2`=9 → 1.
- A=R-type mul, `a_write`=4, B `b_read1`=4 → 1 with `STALL_LOGIC_MULDIV_EN`, 0 without.
- `CNT_W`=4, hold a stall for 20 cycles → count saturates at 15. Pulse `reset` → `stall_q`=0, `stall_count`=0, and `stallLW`=0 during reset.

Source files
------------

// File: rtl/stall_logic.sv
// stall_logic: load-use hazard detector between D/X (A, producer) and F/D (B, consumer).
// Build option: define STALL_LOGIC_MULDIV_EN to also stall on R-type mul/div producers.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   is_not_noop           A is a real instruction (not a bubble)
//   opcodeA/alu_opcodeA   opcode and ALU op of A
//   opcodeB/alu_opcodeB   opcode and ALU op of B
//   a_write               destination register of A
//   b_read1/b_read2       decoded source registers of B
//   stallLW               combinational stall request (hold F/D and PC, bubble D/X)
//   stall_q               stallLW delayed by one cycle
//   stall_count           saturating count of stall cycles since reset
module stall_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_not_noop,
    input  logic [4:0]       opcodeA,
    input  logic [4:0]       opcodeB,
    input  logic [4:0]       alu_opcodeA,
    input  logic [4:0]       alu_opcodeB,
    input  logic [4:0]       a_write,
    input  logic [4:0]       b_read2,
    input  logic [4:0]       b_read1,
    output logic             stallLW,
    output logic             stall_q,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
`ifdef STALL_LOGIC_MULDIV_EN
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
`endif

    logic             prod_a;
    logic             use1;
    logic             use2;
    logic             stall_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Producer: a valid A whose result is not yet available to B's read stage.
    // Writes to $0 are discarded, so they never create a hazard.
`ifdef STALL_LOGIC_MULDIV_EN
    assign prod_a = is_not_noop && (a_write != 5'd0) &&
                    ((opcodeA == OP_LW) ||
                     ((opcodeA == OP_RTYPE) &&
                      ((alu_opcodeA == ALU_MUL) ||
                       (alu_opcodeA == ALU_DIV))));
`else
    assign prod_a = is_not_noop && (a_write != 5'd0) &&
                    (opcodeA == OP_LW);

    logic unused_alu_opcode_a;
    assign unused_alu_opcode_a = ^alu_opcodeA;
`endif

    // Which read ports B really consumes. sw's rs2 (store data) is left
    // out: it is forwarded W->M, so it never needs a bubble.
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (opcodeB)
            OP_RTYPE: begin
                use1 = 1'b1;
                use2 = (alu_opcodeB != ALU_SLL) &&
                       (alu_opcodeB != ALU_SRA);
            end
            OP_BNE, OP_BLT: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_JR, OP_ADDI, OP_SW, OP_LW: begin
                use1 = 1'b1;
            end
            OP_BEX: begin
                use2 = 1'b1;
            end
            default: begin
                use1 = 1'b0;
                use2 = 1'b0;
            end
        endcase
    end

    assign stallLW = !reset && prod_a &&
                     ((use1 && (b_read1 == a_write)) ||
                      (use2 && (b_read2 == a_write)));

    assign stall_d = stallLW;

    // Saturating counter: holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stallLW && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_stall_logic.sv
// tb_stall_logic: randomized + directed check of stall_logic against a
// behavioural model built from opcode use tables and an integer counter.
module tb_stall_logic;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             is_not_noop;
    logic [4:0]       opcodeA, opcodeB, alu_opcodeA, alu_opcodeB;
    logic [4:0]       a_write, b_read2, b_read1;
    logic             stallLW, stall_q;
    logic [CNT_W-1:0] stall_count;

    int n_vec  = 0;
    int n_fail = 0;

    // model state
    bit m_valid = 0;
    bit m_q     = 0;
    int m_cnt   = 0;

    stall_logic #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .is_not_noop (is_not_noop),
        .opcodeA     (opcodeA),
        .opcodeB     (opcodeB),
        .alu_opcodeA (alu_opcodeA),
        .alu_opcodeB (alu_opcodeB),
        .a_write     (a_write),
        .b_read2     (b_read2),
        .b_read1     (b_read1),
        .stallLW     (stallLW),
        .stall_q     (stall_q),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    function automatic bit in_list(input int v, input int l[$]);
        foreach (l[i]) if (l[i] == v) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        int u1[$] = '{0, 2, 4, 5, 6, 7, 8};
        int u2[$] = '{2, 6, 22};
        int sh[$] = '{4, 5};
        int md[$] = '{6, 7};
        bit use1, use2, prod;
        use1 = in_list(int'(opcodeB), u1);
        use2 = in_list(int'(opcodeB), u2) ||
               (opcodeB == 0 && !in_list(int'(alu_opcodeB), sh));
        prod = (opcodeA == 8);
`ifdef STALL_LOGIC_MULDIV_EN
        prod = prod || (opcodeA == 0 && in_list(int'(alu_opcodeA), md));
`endif
        prod = prod && is_not_noop && (a_write != 0);
        if (reset) return 0;
        return prod && ((use1 && b_read1 == a_write) ||
                        (use2 && b_read2 == a_write));
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // model register update on the same edge as the DUT
    always @(posedge clock) begin
        bit s;
        s = model_stall();
        if (reset) begin
            m_q = 0;
            m_cnt = 0;
            m_valid = 1;
        end else begin
            m_q = s;
            if (s && m_cnt < CMAX) m_cnt++;
        end
    end

    // per-cycle compare away from the active edge
    always @(negedge clock) begin
        if (m_valid) begin
            chk("stallLW", int'(stallLW), int'(model_stall()));
            chk("stall_q", int'(stall_q), int'(m_q));
            chk("stall_count", int'(stall_count), m_cnt);
        end
    end

    task automatic drive(input bit v, input int oa, input int aa,
                         input int ob, input int ab, input int aw,
                         input int r2, input int r1);
        is_not_noop = v;
        opcodeA     = 5'(oa);
        alu_opcodeA = 5'(aa);
        opcodeB     = 5'(ob);
        alu_opcodeB = 5'(ab);
        a_write     = 5'(aw);
        b_read2     = 5'(r2);
        b_read1     = 5'(r1);
    endtask

    // step to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick_op();
        int pool[$] = '{0, 2, 4, 5, 6, 7, 8, 22};
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 31));
        return pool[$urandom_range(0, pool.size() - 1)];
    endfunction

    function automatic int pick_alu();
        int pool[$] = '{0, 4, 5, 6, 7};
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 31));
        return pool[$urandom_range(0, pool.size() - 1)];
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1;
        chk("lit_reset_stallLW", int'(stallLW), 0);
        chk("lit_reset_q", int'(stall_q), 0);
        chk("lit_reset_cnt", int'(stall_count), 0);
        reset = 1'b0;

        // lw r5 ; add using r5
        drive(1, 8, 0, 0, 0, 5, 0, 5);
        #1 chk("lit_lw_add", int'(stallLW), 1);
        step();
        chk("lit_cnt_1", int'(stall_count), 1);
        chk("lit_q_1", int'(stall_q), 1);

        // sw data port never stalls, base port does
        drive(1, 8, 0, 7, 0, 5, 5, 7);
        #1 chk("lit_sw_data", int'(stallLW), 0);
        b_read1 = 5'd5;
        #1 chk("lit_sw_base", int'(stallLW), 1);
        step();
        chk("lit_cnt_2", int'(stall_count), 2);

        drive(1, 8, 0, 0, 0, 0, 0, 0);
        #1 chk("lit_r0", int'(stallLW), 0);
        drive(0, 8, 0, 0, 0, 5, 5, 5);
        #1 chk("lit_noop", int'(stallLW), 0);
        drive(1, 8, 0, 0, 4, 9, 9, 3);
        #1 chk("lit_sll", int'(stallLW), 0);
        drive(1, 8, 0, 2, 0, 9, 9, 3);
        #1 chk("lit_bne", int'(stallLW), 1);
        drive(1, 0, 6, 0, 0, 4, 0, 4);
`ifdef STALL_LOGIC_MULDIV_EN
        #1 chk("lit_mul", int'(stallLW), 1);
`else
        #1 chk("lit_mul", int'(stallLW), 0);
`endif
        step();

        // saturation
        reset = 1'b1;
        drive(1, 8, 0, 0, 0, 5, 0, 5);
        #1 chk("lit_rst_force", int'(stallLW), 0);
        step();
        reset = 1'b0;
        repeat (20) step();
        chk("lit_sat", int'(stall_count), 15);
        chk("lit_sat_q", int'(stall_q), 1);
        reset = 1'b1;
        #1 chk("lit_rst_mid", int'(stallLW), 0);
        step();
        chk("lit_rst_cnt", int'(stall_count), 0);
        chk("lit_rst_q", int'(stall_q), 0);
        reset = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 9) < 6) ? 8 : pick_op(),
                  pick_alu(), pick_op(), pick_alu(),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            step();
        end
        reset = 1'b0;
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
